// File: rtl/lsu_bus_master_pkg.sv
// lsu_bus_master_pkg: shared memory-op, FSM-state and byte-enable definitions for the LSU
package lsu_bus_master_pkg;
  typedef enum logic [2:0] {
    MEMOP_LW, MEMOP_LBU, MEMOP_LB, MEMOP_LHU, MEMOP_LH, MEMOP_SW, MEMOP_SB, MEMOP_SH
  } memop_e;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  function automatic logic is_store(memop_e op);
    return op inside {MEMOP_SW, MEMOP_SB, MEMOP_SH};
  endfunction
endpackage

// File: rtl/lsu_lane_format.sv
// lsu_lane_format: combinational byte-lane steering (BE, replicated store data, extended load data, alignment)
module lsu_lane_format
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        aligned
);
  memop_e      op;
  logic [7:0]  byt;
  logic [15:0] hw;
  assign op  = memop_e'(mem_op);
  assign byt = 8'(bus_rdata >> {addr_lo, 3'b000});
  assign hw  = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  always_comb begin
    be        = op == MEMOP_SB ? BE_BYTE << addr_lo :
                op == MEMOP_SH ? (addr_lo[1] ? BE_HHI : BE_HLO) : BE_WORD;
    wdata_rep = op == MEMOP_SW ? wdata :
                op == MEMOP_SB ? {4{wdata[7:0]}} :
                op == MEMOP_SH ? {2{wdata[15:0]}} : '0;
    rdata_ext = op == MEMOP_LBU ? {24'b0, byt} :
                op == MEMOP_LB  ? {{24{byt[7]}}, byt} :
                op == MEMOP_LHU ? {16'b0, hw} :
                op == MEMOP_LH  ? {{16{hw[15]}}, hw} : bus_rdata;
    aligned   = op inside {MEMOP_LW, MEMOP_SW}              ? addr_lo == 2'b00 :
                op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH}   ? !addr_lo[0] : 1'b1;
  end
endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: M-stage load/store unit issuing one byte-enabled req/ack bus transaction per memory op
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [2:0]  MemOp,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] RData,
  output logic        AdEL,
  output logic        AdES,
  output logic        BusErr,
  output logic        BusReq,
  output logic        BusWE,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBE,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);
  localparam int CW = $clog2(TIMEOUT);
  state_e        state, state_n;
  memop_e        op_q, op_n, fmt_op;
  logic [1:0]    lo_q, lo_n, fmt_lo;
  logic [CW-1:0] cnt, cnt_n;
  logic          req_n, we_n, done_n, adel_n, ades_n, err_n, aligned;
  logic [31:0]   addr_n, wd_n, rdata_n, wdr, rext;
  logic [3:0]    be_n, be;
  assign fmt_op = state == IDLE ? memop_e'(MemOp) : op_q;
  assign fmt_lo = state == IDLE ? Addr[1:0] : lo_q;
  assign Stall  = state == REQ || (state == IDLE && ReqValid);
  lsu_lane_format u_fmt (
    .mem_op   (fmt_op),
    .addr_lo  (fmt_lo),
    .wdata    (WData),
    .bus_rdata(BusRData),
    .be       (be),
    .wdata_rep(wdr),
    .rdata_ext(rext),
    .aligned  (aligned)
  );
  always_comb begin
    state_n = state;
    op_n    = op_q;
    lo_n    = lo_q;
    cnt_n   = cnt;
    req_n   = BusReq;
    we_n    = BusWE;
    addr_n  = BusAddr;
    be_n    = BusBE;
    wd_n    = BusWData;
    rdata_n = RData;
    done_n  = 1'b0;
    adel_n  = 1'b0;
    ades_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (ReqValid) begin
        op_n    = fmt_op;
        lo_n    = Addr[1:0];
        if (aligned) begin
          state_n = REQ;
          req_n   = 1'b1;
          we_n    = is_store(fmt_op);
          addr_n  = {Addr[31:2], 2'b00};
          be_n    = be;
          wd_n    = wdr;
          cnt_n   = '0;
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
          adel_n  = !is_store(fmt_op);
          ades_n  = is_store(fmt_op);
          rdata_n = '0;
        end
      end
      REQ: if (BusAck) begin
        state_n = DONE;
        req_n   = 1'b0;
        done_n  = 1'b1;
        rdata_n = is_store(op_q) ? '0 : rext;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        state_n = DONE;
        req_n   = 1'b0;
        done_n  = 1'b1;
        err_n   = 1'b1;
        rdata_n = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      state    <= IDLE;
      op_q     <= MEMOP_LW;
      lo_q     <= '0;
      cnt      <= '0;
      BusReq   <= 1'b0;
      BusWE    <= 1'b0;
      BusAddr  <= '0;
      BusBE    <= '0;
      BusWData <= '0;
      RData    <= '0;
      Done     <= 1'b0;
      AdEL     <= 1'b0;
      AdES     <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      lo_q     <= lo_n;
      cnt      <= cnt_n;
      BusReq   <= req_n;
      BusWE    <= we_n;
      BusAddr  <= addr_n;
      BusBE    <= be_n;
      BusWData <= wd_n;
      RData    <= rdata_n;
      Done     <= done_n;
      AdEL     <= adel_n;
      AdES     <= ades_n;
      BusErr   <= err_n;
    end
endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit on the CPU side of the data-memory interface. It sits in the M stage.
- Turns one pipeline memory operation into a single word-aligned, byte-enabled transaction on a req/ack data bus.
- It waits a variable number of cycles for the response, then returns sign- or zero-extended load data.
- It stalls the pipeline while a transaction is in flight and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 64, cycles BusReq may stay high without BusAck before BusErr is raised (min 2).

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- ReqValid  in  1  M stage holds a memory op; Addr/WData/MemOp stay stable while Stall=1.
- Addr  in  32  byte address.
- WData  in  32  store data; only the low byte/half is used for SB/SH.
- MemOp  in  3  0 LW, 1 LBU, 2 LB, 3 LHU, 4 LH, 5 SW, 6 SB, 7 SH.
- Stall  out  1  freeze pipeline.
- Done  out  1  one-cycle pulse: op retired, RData valid.
- RData  out  32  extended load data; 0 for stores.
- AdEL  out  1  misaligned load pulse.
- AdES  out  1  misaligned store pulse.
- BusErr  out  1  timeout pulse.
- BusReq  out  1  request valid.
- BusWE  out  1  1 = write.
- BusAddr  out  32  {Addr[31:2],2'b00}.
- BusBE  out  4  byte enables.
- BusWData  out  32  lane-replicated store data.
- BusAck  in  1  responder completes the current request this cycle.
- BusRData  in  32  read word, valid when BusAck=1 and BusWE=0.

Behaviour:
- States: IDLE, REQ, DONE. All bus outputs and status pulses are registered.
- Reset (async, Reset=0) forces: state IDLE, BusReq 0, BusWE 0, BusAddr 0, BusBE 0, BusWData 0, RData 0, Done/AdEL/AdES/BusErr 0, timeout counter 0.
- Reset mid-transaction drops BusReq immediately. Any late BusAck is ignored.
- Alignment rule: LW/SW need Addr[1:0]=0. LH/LHU/SH need Addr[0]=0. Byte ops are always aligned.
- IDLE with ReqValid=0: nothing happens, Stall=0.
- IDLE, ReqValid=1, aligned:
  - Latch op, Addr[1:0], BusAddr, BusBE, BusWData and BusWE.
  - Set BusReq=1 and go to REQ.
  - Stall=1 combinationally in this same cycle.
- IDLE, ReqValid=1, misaligned:
  - No bus cycle. Go to DONE.
  - AdEL (load) or AdES (store) and Done pulse in the DONE cycle. RData=0.
- BusBE:
  - SW = 1111.
  - SB = 0001 << Addr[1:0].
  - SH = Addr[1] ? 1100 : 0011.
  - Loads = 1111.
- BusWData:
  - SW = WData.
  - SB = {4{WData[7:0]}}.
  - SH = {2{WData[15:0]}}.
  - Loads = 0.
- REQ:
  - BusReq and all bus fields are held constant. Counter increments each cycle.
  - On BusAck=1: drop BusReq next edge. For loads, capture the extracted BusRData into RData. Go to DONE.
  - Counter reaching TIMEOUT-1 without ack: drop BusReq, RData=0, BusErr pulse in DONE.
  - If BusAck arrives in the same cycle as the timeout, BusAck wins.
  - Stall=1 throughout.
- DONE:
  - Done=1 and Stall=0 for exactly one cycle; the pipeline advances on this edge.
  - Next state is IDLE. The op now in M stage is evaluated in the following cycle, so a back-to-back op incurs a 1-cycle IDLE gap.
- Load extraction uses b = Addr[1:0] and h = Addr[1]:
  - LW: the word.
  - LBU: zero-extend byte b.
  - LB: sign-extend byte b.
  - LHU: zero-extend half h.
  - LH: sign-extend half h.
- Minimum latency: a 1-cycle ack gives request issue, REQ, DONE = 3 cycles from ReqValid to Done.
- BusAck while in IDLE or DONE is ignored.

Decomposition:
- Shared package holds:
  - MemOp encodings (MEMOP_LW .. MEMOP_SH).
  - State encodings IDLE/REQ/DONE.
  - Byte-enable constants.
- One sub-module, lsu_lane_format: purely combinational.
  - Store side: BE and replicated write data from (MemOp, Addr[1:0], WData).
  - Load side: extended load data from (MemOp, Addr[1:0], BusRData).
  - Alignment check.

Test Plan:
- SW Addr=0x104, WData=0xDEADBEEF, ack after 2 cycles:
  - BusAddr=0x104, BE=1111, BusWData=0xDEADBEEF, BusWE=1.
  - Stall high until Done; Done 1 cycle.
- SB Addr=0x203, WData=0x000000A5: BusAddr=0x200, BE=1000, BusWData=0xA5A5A5A5.
- LB Addr=0x301, BusRData=0x1234_80FF: RData=0xFFFFFF80.
- LHU Addr=0x302 on the same read data: RData=0x00001234.
- LW Addr=0x102: AdEL pulse, Done pulse, BusReq never asserted, RData=0.
- LW with BusAck held 0, TIMEOUT=4:
  - BusReq high exactly 4 cycles, then BusErr + Done, RData=0.
- SH Addr=0x10: assert Reset=0 while in REQ; BusReq falls without a clock edge.
  - After release, a late BusAck produces no Done.
